// File: rtl/uart_receiver_fifo.sv
// 8N1 UART receiver (LSB first) with a show-ahead receive FIFO.
// Bytes are delivered over a valid/ready handshake; framing and overrun errors pulse for one cycle.
module uart_receiver_fifo #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int BAUD_RATE       = 115200,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          uart_rx,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic                          frame_error,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CYCLES_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int TIMER_W        = $clog2(CYCLES_PER_BIT) + 1;
    localparam int PTR_W          = $clog2(FIFO_DEPTH);
    localparam int CNT_W          = PTR_W + 1;

    // Timer reloads are one less than the wanted period because expiry is the cycle that reads zero.
    localparam logic [TIMER_W-1:0] HALF_RELOAD = TIMER_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [TIMER_W-1:0] FULL_RELOAD = TIMER_W'(CYCLES_PER_BIT - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    generate
        if (CYCLES_PER_BIT < 4) begin : g_bad_rate
            $error("uart_receiver_fifo: CYCLES_PER_BIT must be at least 4");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("uart_receiver_fifo: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    logic               sync1_q, sync2_q;
    logic [1:0]         state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               frame_error_q, frame_error_d;
    logic               overrun_q, overrun_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [7:0]         mem_q [FIFO_DEPTH];

    logic tick, push_req, push_ok, pop, full;

    assign tick = (timer_q == '0);

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        push_req      = 1'b0;
        frame_error_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!sync2_q) begin
                    timer_d = HALF_RELOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (!tick) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else if (!sync2_q) begin
                    timer_d   = FULL_RELOAD;
                    bit_idx_d = '0;
                    state_d   = ST_DATA;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    timer_d = FULL_RELOAD;
                    if (bit_idx_q == 3'd7) state_d = ST_STOP;
                    else                   bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            default: begin
                if (!tick) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else begin
                    state_d       = ST_IDLE;
                    push_req      = sync2_q;
                    frame_error_d = !sync2_q;
                end
            end
        endcase
    end

    always_comb begin
        full      = (count_q == CNT_W'(FIFO_DEPTH));
        rx_valid  = (count_q != '0);
        pop       = rx_valid && rx_ready;
        // A full FIFO still accepts a byte when the head is leaving in the same cycle.
        push_ok   = push_req && (!full || pop);
        overrun_d = push_req && full && !pop;
        wr_ptr_d  = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d   = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q       <= 1'b1;
            sync2_q       <= 1'b1;
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            bit_idx_q     <= '0;
            shift_q       <= '0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            sync1_q       <= uart_rx;
            sync2_q       <= sync1_q;
            state_q       <= state_d;
            timer_q       <= timer_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // NOTE: the storage array is not reset; rx_data is gated by rx_valid so stale entries never show.
    always_ff @(posedge clock) begin
        if (push_ok) mem_q[wr_ptr_q] <= shift_q;
    end

    assign rx_data     = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign frame_error = frame_error_q;
    assign overrun     = overrun_q;
    assign fifo_count  = count_q;

endmodule

// File: tb/tb_uart_receiver_fifo.sv
// Self-checking bench for uart_receiver_fifo: a serial driver feeds frames, a queue holds the
// bytes that must come out, and a monitor compares every handshake pop against it.
module tb_uart_receiver_fifo;

    // Bit period scaled down to 32 clocks to keep the run short; the glitch is scaled with it.
    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 1562500;
    localparam int CPB    = CLK_HZ / BAUD;
    localparam int DEPTH  = 16;

    logic       clock;
    logic       reset;
    logic       uart_rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_error;
    logic       overrun;
    logic [$clog2(DEPTH):0] fifo_count;

    int checks   = 0;
    int failures = 0;
    int fe_cnt   = 0;
    int ov_cnt   = 0;
    int pop_cnt  = 0;
    logic [7:0] exp_q [$];

    uart_receiver_fifo #(
        .CLOCK_FREQUENCY(CLK_HZ),
        .BAUD_RATE      (BAUD),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .uart_rx    (uart_rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .frame_error(frame_error),
        .overrun    (overrun),
        .fifo_count (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One 8N1 frame; a bad stop bit is held low for 3/4 of a bit so the line is high again
    // before the receiver's follow-up start check.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok);
        @(negedge clock);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        if (stop_ok) begin
            uart_rx = 1'b1;
            repeat (CPB - 1) @(negedge clock);
        end else begin
            uart_rx = 1'b0;
            repeat (CPB * 3 / 4) @(negedge clock);
            uart_rx = 1'b1;
            repeat (CPB) @(negedge clock);
        end
    endtask

    always @(negedge clock) begin
        if (reset && rx_valid && rx_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) check("pop_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else                   check("pop_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
        if (frame_error) fe_cnt++;
        if (overrun)     ov_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int pops_before;
        logic [7:0] hello [6];
        hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C;
        hello[3] = 8'h6C; hello[4] = 8'h6F; hello[5] = 8'h0A;

        reset    = 1'b0;
        uart_rx  = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_rx_data", 32'(rx_data), 0);
        check("reset_rx_valid", 32'(rx_valid), 0);
        check("reset_fifo_count", 32'(fifo_count), 0);
        check("reset_flags", 32'({frame_error, overrun}), 0);
        reset = 1'b1;
        repeat (4) @(negedge clock);

        // 1: single byte held in the FIFO, latency from line fall to rx_valid
        exp_q.push_back(8'h48);
        fork
            send_frame(8'h48, 1'b1);
            begin
                @(negedge clock);
                cyc = 0;
                while (!rx_valid && cyc < 20 * CPB) begin
                    @(negedge clock);
                    cyc++;
                end
            end
        join
        check("t1_latency_in_range", 32'(cyc >= 9 * CPB && cyc <= 10 * CPB), 1);
        repeat (5) @(negedge clock);
        check("t1_rx_valid", 32'(rx_valid), 1);
        check("t1_rx_data", 32'(rx_data), 32'h48);
        check("t1_fifo_count", 32'(fifo_count), 1);
        check("t1_no_errors", 32'(fe_cnt + ov_cnt), 0);
        rx_ready = 1'b1;
        repeat (4) @(negedge clock);
        check("t1_drained", 32'(fifo_count), 0);

        // 2: back-to-back "Hello\n" with the consumer always ready
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(hello[i]);
            send_frame(hello[i], 1'b1);
        end
        repeat (10) @(negedge clock);
        check("t2_fifo_count", 32'(fifo_count), 0);
        check("t2_queue_empty", 32'(exp_q.size()), 0);
        check("t2_pop_count", 32'(pop_cnt), 7);

        // 3: short low glitch on an idle line
        uart_rx = 1'b0;
        repeat (8) @(negedge clock);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        check("t3_no_push", 32'(fifo_count), 0);
        check("t3_no_frame_error", 32'(fe_cnt), 0);

        // 4: bad stop bit
        rx_ready = 1'b0;
        send_frame(8'h55, 1'b0);
        repeat (CPB) @(negedge clock);
        check("t4_frame_error_pulses", 32'(fe_cnt), 1);
        check("t4_fifo_count", 32'(fifo_count), 0);
        check("t4_rx_valid", 32'(rx_valid), 0);

        // 5: fill past capacity, then drain
        for (int i = 0; i < 17; i++) begin
            if (i < DEPTH) exp_q.push_back(8'(i));
            send_frame(8'(i), 1'b1);
        end
        repeat (5) @(negedge clock);
        check("t5_fifo_full_count", 32'(fifo_count), DEPTH);
        check("t5_overrun_pulses", 32'(ov_cnt), 1);
        check("t5_head_data", 32'(rx_data), 0);
        rx_ready = 1'b1;
        repeat (DEPTH + 4) @(negedge clock);
        check("t5_drained_count", 32'(fifo_count), 0);
        check("t5_queue_empty", 32'(exp_q.size()), 0);

        // 6: reset in the middle of a frame with a byte already held
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        repeat (5) @(negedge clock);
        check("t6_pre_reset_count", 32'(fifo_count), 1);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 3; i++) begin
            uart_rx = i[0];
            repeat (CPB) @(negedge clock);
        end
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("t6_reset_rx_data", 32'(rx_data), 0);
        check("t6_reset_rx_valid", 32'(rx_valid), 0);
        check("t6_reset_fifo_count", 32'(fifo_count), 0);
        check("t6_reset_flags", 32'({frame_error, overrun}), 0);
        uart_rx = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2 * CPB) @(negedge clock);
        check("t6_no_partial_byte", 32'(fifo_count), 0);
        pops_before = pop_cnt;
        exp_q.push_back(8'hA5);
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        repeat (2 * CPB) @(negedge clock);
        check("t6_single_pop", 32'(pop_cnt - pops_before), 1);
        check("t6_queue_empty", 32'(exp_q.size()), 0);
        check("t6_error_totals", 32'({fe_cnt[7:0], ov_cnt[7:0]}), 32'h0101);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
